// File: rtl/adder_arbiter_if.sv
// adder_arbiter_if
//   Groups the requester handshakes, the shared-adder operand/result bus and
//   the response strobes of adder_arbiter into one bundle.
//
//   Parameter:
//     INP_DW      operand width; sums are INP_DW+1 bits wide
//
//   Signals:
//     req0_valid/req0_ready/req0_a/req0_b   requester 0 handshake + operands
//     req1_valid/req1_ready/req1_a/req1_b   requester 1 handshake + operands
//     add_a/add_b                           operands to the shared adder
//     add_sum                               result from the shared adder
//     rsp0_valid/rsp1_valid                 one-cycle result strobes
//     rsp_data                              result value
//     busy                                  at least one result in flight
//
//   Modports:
//     slave   the arbiter's view (drives readys, adder operands, responses)
//     master  the surrounding system's view (requesters plus the adder)

interface adder_arbiter_if #(
  parameter int INP_DW = 3
);

  logic              req0_valid;
  logic              req0_ready;
  logic [INP_DW-1:0] req0_a;
  logic [INP_DW-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [INP_DW-1:0] req1_a;
  logic [INP_DW-1:0] req1_b;

  logic [INP_DW-1:0] add_a;
  logic [INP_DW-1:0] add_b;
  logic [INP_DW:0]   add_sum;

  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [INP_DW:0]   rsp_data;
  logic              busy;

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  add_sum,
    output req0_ready, req1_ready,
    output add_a, add_b,
    output rsp0_valid, rsp1_valid, rsp_data, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output add_sum,
    input  req0_ready, req1_ready,
    input  add_a, add_b,
    input  rsp0_valid, rsp1_valid, rsp_data, busy
  );

endinterface

// File: rtl/adder_arbiter.sv
// adder_arbiter
//   Shares one external pipelined adder between two requesters. At most one
//   operand pair is granted per cycle. A tag pipeline tracks which requester
//   owns each result, so the matching response strobe fires when the sum
//   leaves the adder NUM_REG cycles later.
//
//   Parameters:
//     INP_DW    operand width of the shared adder
//     NUM_REG   adder latency in cycles (1..8)
//
//   Ports:
//     clk       clock, rising edge
//     rst       synchronous, active-low reset
//     bus       adder_arbiter_if.slave (handshakes, adder bus, responses)
//
//   Configuration:
//     ADDER_ARBITER_RR_EN  defined   -> round-robin arbitration on contention
//                          undefined -> fixed priority, requester 0 wins

module adder_arbiter #(
  parameter int INP_DW  = 3,
  parameter int NUM_REG = 2
) (
  input logic            clk,
  input logic            rst,
  adder_arbiter_if.slave bus
);

  logic               grant0;
  logic               grant1;
  logic               xfer;
  logic [INP_DW-1:0]  sel_a;
  logic [INP_DW-1:0]  sel_b;
  logic [NUM_REG-1:0] tag_valid;
  logic [NUM_REG-1:0] tag_id;
  logic               rsp0;
  logic               rsp1;

`ifdef ADDER_ARBITER_RR_EN
  // last_grant = 1 means requester 1 won the most recent transfer, so
  // requester 0 gets the next contended cycle.
  logic last_grant;

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end
  end

  // The pointer moves only when a transfer actually happens.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_grant <= 1'b1;
    end else if (xfer) begin
      last_grant <= grant1;
    end
  end
`else
  // Fixed priority: requester 0 always wins.
  always_comb begin
    grant0 = rst && bus.req0_valid;
    grant1 = rst && bus.req1_valid && !bus.req0_valid;
  end
`endif

  // A grant is only ever given to a valid requester, so any grant is a transfer.
  assign xfer = grant0 || grant1;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    if (grant0) begin
      sel_a = bus.req0_a;
      sel_b = bus.req0_b;
    end else if (grant1) begin
      sel_a = bus.req1_a;
      sel_b = bus.req1_b;
    end
  end

  // Tag pipeline mirrors the adder latency: stage 0 holds the tag of the
  // pair issued one cycle ago, stage NUM_REG-1 lines up with add_sum.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid[0] <= xfer;
      tag_id[0]    <= grant1;
      for (int i = 1; i < NUM_REG; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_id[i]    <= tag_id[i-1];
      end
    end
  end

  // Outputs are gated by rst so that everything reads zero during reset,
  // including the cycle before the first reset edge clears the tags.
  assign rsp0 = rst && tag_valid[NUM_REG-1] && !tag_id[NUM_REG-1];
  assign rsp1 = rst && tag_valid[NUM_REG-1] &&  tag_id[NUM_REG-1];

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.add_a      = sel_a;
  assign bus.add_b      = sel_b;
  assign bus.rsp0_valid = rsp0;
  assign bus.rsp1_valid = rsp1;
  assign bus.rsp_data   = (rsp0 || rsp1) ? bus.add_sum : '0;
  assign bus.busy       = rst && (|tag_valid);

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter
//   Self-checking bench for adder_arbiter (INP_DW=3, NUM_REG=2). It provides a
//   behavioural two-stage pipelined adder on the shared adder bus. It then
//   replays a cycle-by-cycle table of inputs with hand-computed outputs,
//   followed by hand-written sequences for pointer movement and mid-flight
//   reset. Expectations follow ADDER_ARBITER_RR_EN when it is defined.

module tb_adder_arbiter;

  localparam int INP_DW  = 3;
  localparam int NUM_REG = 2;

`ifdef ADDER_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic              rst;
    logic              v0;
    logic [INP_DW-1:0] a0;
    logic [INP_DW-1:0] b0;
    logic              v1;
    logic [INP_DW-1:0] a1;
    logic [INP_DW-1:0] b1;
    logic              r0;
    logic              r1;
    logic [INP_DW-1:0] ea;
    logic [INP_DW-1:0] eb;
    logic              s0;
    logic              s1;
    logic [INP_DW:0]   d;
    logic              bz;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  adder_arbiter_if #(.INP_DW(INP_DW)) bus ();

  adder_arbiter #(
    .INP_DW (INP_DW),
    .NUM_REG(NUM_REG)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared adder: operands in cycle t give the sum in cycle t+NUM_REG.
  logic [INP_DW:0] pipe [NUM_REG];

  always_ff @(posedge clk) begin
    pipe[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b};
    for (int i = 1; i < NUM_REG; i++) pipe[i] <= pipe[i-1];
  end

  assign bus.add_sum = pipe[NUM_REG-1];

  function automatic vec_t mk(input int rst_i, input int v0, input int a0, input int b0,
                              input int v1, input int a1, input int b1,
                              input int r0, input int r1, input int ea, input int eb,
                              input int s0, input int s1, input int d, input int bz);
    vec_t v;
    v.rst = rst_i[0];
    v.v0  = v0[0];
    v.a0  = a0[INP_DW-1:0];
    v.b0  = b0[INP_DW-1:0];
    v.v1  = v1[0];
    v.a1  = a1[INP_DW-1:0];
    v.b1  = b1[INP_DW-1:0];
    v.r0  = r0[0];
    v.r1  = r1[0];
    v.ea  = ea[INP_DW-1:0];
    v.eb  = eb[INP_DW-1:0];
    v.s0  = s0[0];
    v.s1  = s1[0];
    v.d   = d[INP_DW:0];
    v.bz  = bz[0];
    return v;
  endfunction

  task automatic chk(input string nm, input int cyc, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("[TB] FAIL %s step %0d: got %0d, expected %0d", nm, cyc, act, exp_v);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst            = v.rst;
    bus.req0_valid = v.v0;
    bus.req0_a     = v.a0;
    bus.req0_b     = v.b0;
    bus.req1_valid = v.v1;
    bus.req1_a     = v.a1;
    bus.req1_b     = v.b1;
  endtask

  task automatic checkOutput(input vec_t v, input string tag, input int cyc);
    chk({tag, ".req0_ready"}, cyc, int'(bus.req0_ready), int'(v.r0));
    chk({tag, ".req1_ready"}, cyc, int'(bus.req1_ready), int'(v.r1));
    chk({tag, ".add_a"},      cyc, int'(bus.add_a),      int'(v.ea));
    chk({tag, ".add_b"},      cyc, int'(bus.add_b),      int'(v.eb));
    chk({tag, ".rsp0_valid"}, cyc, int'(bus.rsp0_valid), int'(v.s0));
    chk({tag, ".rsp1_valid"}, cyc, int'(bus.rsp1_valid), int'(v.s1));
    chk({tag, ".rsp_data"},   cyc, int'(bus.rsp_data),   int'(v.d));
    chk({tag, ".busy"},       cyc, int'(bus.busy),       int'(v.bz));
  endtask

  // One clock cycle: drive just after the rising edge, sample on the falling edge.
  task automatic runVec(input vec_t v, input string tag, input int cyc);
    @(posedge clk);
    #1;
    applyStimulus(v);
    @(negedge clk);
    checkOutput(v, tag, cyc);
  endtask

  vec_t tbl[$];
  vec_t seq[$];

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req0_a = '0;
    bus.req0_b = '0;
    bus.req1_valid = 1'b0;
    bus.req1_a = '0;
    bus.req1_b = '0;

    //              rst v0 a0 b0 v1 a1 b1   r0        r1        ea        eb        s0        s1        d         bz
    // reset held with both requesters valid
    tbl.push_back(mk(0, 1, 1, 1, 1, 2, 2,   0,        0,        0,        0,        0,        0,        0,        0));
    tbl.push_back(mk(0, 1, 1, 1, 1, 2, 2,   0,        0,        0,        0,        0,        0,        0,        0));
    // req0 3+5 -> rsp0 8 two cycles later
    tbl.push_back(mk(1, 1, 3, 5, 0, 0, 0,   1,        0,        3,        5,        0,        0,        0,        0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        0,        0,        0,        1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        1,        0,        8,        1));
    // req1 7+7 -> rsp1 14, carry kept
    tbl.push_back(mk(1, 0, 0, 0, 1, 7, 7,   0,        1,        7,        7,        0,        0,        0,        0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        0,        0,        0,        1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        0,        1,        14,       1));
    // contention for four cycles, (1,1) vs (2,2); pointer says req1 went last
    tbl.push_back(mk(1, 1, 1, 1, 1, 2, 2,   1,        0,        1,        1,        0,        0,        0,        0));
    tbl.push_back(mk(1, 1, 1, 1, 1, 2, 2,   RR?0:1,   RR?1:0,   RR?2:1,   RR?2:1,   0,        0,        0,        1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 2, 2,   1,        0,        1,        1,        1,        0,        2,        1));
    tbl.push_back(mk(1, 1, 1, 1, 1, 2, 2,   RR?0:1,   RR?1:0,   RR?2:1,   RR?2:1,   RR?0:1,   RR?1:0,   RR?4:2,   1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        1,        0,        2,        1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        RR?0:1,   RR?1:0,   RR?4:2,   1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        0,        0,        0,        0));
    // req1 back-to-back 1+0, 2+0, 3+0
    tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0,   0,        1,        1,        0,        0,        0,        0,        0));
    tbl.push_back(mk(1, 0, 0, 0, 1, 2, 0,   0,        1,        2,        0,        0,        0,        0,        1));
    tbl.push_back(mk(1, 0, 0, 0, 1, 3, 0,   0,        1,        3,        0,        0,        1,        1,        1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        0,        1,        2,        1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        0,        1,        3,        1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        0,        0,        0,        0));

    foreach (tbl[i]) runVec(tbl[i], "tbl", i);

    // Pointer moves on a lone req0 transfer; the following contention then
    // goes to req1 under round-robin and to req0 under fixed priority.
    seq.push_back(mk(1, 1, 4, 1, 0, 0, 0,   1,        0,        4,        1,        0,        0,        0,        0));
    seq.push_back(mk(1, 1, 1, 1, 1, 2, 3,   RR?0:1,   RR?1:0,   RR?2:1,   RR?3:1,   0,        0,        0,        1));
    seq.push_back(mk(1, 1, 1, 1, 0, 0, 0,   1,        0,        1,        1,        1,        0,        5,        1));
    seq.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        RR?0:1,   RR?1:0,   RR?5:2,   1));
    seq.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        1,        0,        2,        1));
    seq.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        0,        0,        0,        0));
    foreach (seq[i]) runVec(seq[i], "ptr", i);

    // Two req0 pairs accepted, then reset: their results must never appear.
    seq.delete();
    seq.push_back(mk(1, 1, 1, 2, 0, 0, 0,   1,        0,        1,        2,        0,        0,        0,        0));
    seq.push_back(mk(1, 1, 2, 2, 0, 0, 0,   1,        0,        2,        2,        0,        0,        0,        1));
    seq.push_back(mk(0, 1, 3, 3, 1, 1, 1,   0,        0,        0,        0,        0,        0,        0,        0));
    seq.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        0,        0,        0,        0));
    seq.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,        0,        0,        0,        0,        0,        0,        0));
    foreach (seq[i]) runVec(seq[i], "rstmid", i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
